clk_div_monitor: RTL and testbench

//   Receiving-end checker for synchronous integer clock dividers. Samples a divided

---
 rtl/clk_div_monitor.sv | 150 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
//   Receiving-end checker for synchronous integer clock dividers. The divided
//   clock is resynchronised into the source clock domain. Each rising edge
//   closes one period, whose length and high time are measured in i_clk
//   cycles and compared against the expected ratio N. The block reports lock
//   after LOCK_CNT consecutive good periods, and it holds sticky error and
//   timeout flags.
//
// Ports
//   i_clk         source clock (the clock that also drives the divider)
//   i_rst_n       synchronous active-low reset
//   i_en          monitor enable; low returns the FSM to IDLE
//   i_div_clk     divided clock under test
//   i_div_ratio   expected ratio N, latched when leaving IDLE
//   i_err_clr     clears the sticky o_err / o_timeout flags
//   o_period      last measured period (rise to rise)
//   o_high        last measured high time
//   o_period_vld  one-cycle pulse when o_period / o_high update
//   o_locked      LOCK_CNT consecutive good periods seen
//   o_err         sticky: bad period, bad high time or timeout
//   o_timeout     sticky: no rising edge within 2*N cycles
// -----------------------------------------------------------------------------
module clk_div_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_div_clk,
    input  logic [CNT_W-1:0] i_div_ratio,
    input  logic             i_err_clr,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_period_vld,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_timeout
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] ALL1 = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt, hcnt, n_lat;
    logic [GW-1:0]    good_cnt;

    logic             rise;
    logic [CNT_W-1:0] cnt_inc, hcnt_inc;
    logic [CNT_W:0]   tmo_lim, n_floor, n_ceil;
    logic             period_good, cap, bad_cap, tmo_ev;

    always_comb begin
        rise     = s2 & ~s3;
        cnt_inc  = (cnt == ALL1) ? cnt : cnt + 1'b1;
        hcnt_inc = (hcnt == ALL1 || !s2) ? hcnt : hcnt + 1'b1;
        // One bit wider, so 2*N and ceil(N/2) never wrap.
        tmo_lim  = {n_lat, 1'b0};
        n_floor  = {1'b0, n_lat} >> 1;
        n_ceil   = ({1'b0, n_lat} + 1'b1) >> 1;
        // A ratio below 2 cannot be produced by a divider, so it never matches.
        period_good = (n_lat >= CNT_W'(2)) && (cnt == n_lat) &&
                      ({1'b0, hcnt} >= n_floor) && ({1'b0, hcnt} <= n_ceil);
        cap     = i_en && rise && (state == MEASURE || state == LOCKED);
        bad_cap = cap && !period_good;
        // An exact compare fires once per dead stretch. cnt keeps counting
        // past the limit until the next rise.
        tmo_ev  = i_en && (state != IDLE) && !rise && ({1'b0, cnt} == tmo_lim);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            hcnt         <= '0;
            n_lat        <= '0;
            good_cnt     <= '0;
            o_period     <= '0;
            o_high       <= '0;
            o_period_vld <= 1'b0;
            o_locked     <= 1'b0;
            o_err        <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            s1 <= i_div_clk;
            s2 <= s1;
            s3 <= s2;
            o_period_vld <= 1'b0;

            // A new error in the same cycle as a clear wins.
            o_err     <= bad_cap | tmo_ev | (o_err & ~i_err_clr);
            o_timeout <= tmo_ev | (o_timeout & ~i_err_clr);

            if (!i_en) begin
                state    <= IDLE;
                o_locked <= 1'b0;
                good_cnt <= '0;
            end else if (state == IDLE) begin
                n_lat    <= i_div_ratio;
                cnt      <= '0;
                hcnt     <= '0;
                good_cnt <= '0;
                state    <= SYNC;
            end else begin
                if (rise) begin
                    cnt  <= CNT_W'(1);
                    hcnt <= CNT_W'(1);
                end else begin
                    cnt  <= cnt_inc;
                    hcnt <= hcnt_inc;
                end

                if (tmo_ev) begin
                    state    <= SYNC;
                    o_locked <= 1'b0;
                    good_cnt <= '0;
                end else if (rise) begin
                    if (state == SYNC) begin
                        // The first edge only opens a period, so nothing is captured.
                        state <= MEASURE;
                    end else begin
                        o_period     <= cnt;
                        o_high       <= hcnt;
                        o_period_vld <= 1'b1;
                        if (!period_good) begin
                            good_cnt <= '0;
                            o_locked <= 1'b0;
                            state    <= MEASURE;
                        end else if (state == MEASURE) begin
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                o_locked <= 1'b1;
                                state    <= LOCKED;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;

    localparam int CNT_W = 8;
    localparam int LOCK  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             div_clk = 1'b0;
    logic [CNT_W-1:0] div_ratio = '0;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] period, high;
    logic             period_vld, locked, err, timeout;

    clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_clk(div_clk),
        .i_div_ratio(div_ratio), .i_err_clr(err_clr),
        .o_period(period), .o_high(high), .o_period_vld(period_vld),
        .o_locked(locked), .o_err(err), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
        bit bad;
        bit lk;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: latched ratio, good-period streak, and the last
    // full period driven. That period is not yet closed by a rising edge.
    int n_mod = 0;
    int streak = 0;
    bit have_prev = 0;
    int prev_h = 0, prev_l = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_good(int p, int h);
        return n_mod >= 2 && p == n_mod && h >= n_mod / 2 && h <= (n_mod + 1) / 2;
    endfunction

    // Scoreboard monitor: every capture pulse consumes one expected period.
    always @(negedge clk) begin
        if (period_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_vld", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("period", int'(period), e.p);
                check("high", int'(high), e.h);
                check("locked", int'(locked), int'(e.lk));
                if (e.bad) check("err_on_bad", int'(err), 1);
            end
        end
    end

    // Drive one divider period: h cycles high, then l cycles low. The rising
    // edge that starts it closes the previous period, which is queued here.
    // clr_at, when non-negative, pulses err_clr at that cycle of the period.
    task automatic drive_period(int h, int l, int clr_at);
        int len;
        bit tmo;
        len = h + l;
        tmo = (len > 2 * n_mod);
        if (have_prev) begin
            exp_t e;
            e.p   = prev_h + prev_l;
            e.h   = prev_h;
            e.bad = !is_good(e.p, e.h);
            streak = e.bad ? 0 : streak + 1;
            e.lk  = (streak >= LOCK);
            sb.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            div_clk = (i < h);
            err_clr = (i == clr_at);
            if (clr_at == 0 && i == 1) begin
                check("err_clr_alone", int'(err), 0);
                check("tmo_clr_alone", int'(timeout), 0);
            end
        end
        err_clr = 1'b0;
        if (tmo) begin
            check("timeout_flag", int'(timeout), 1);
            check("timeout_err", int'(err), 1);
            check("timeout_unlock", int'(locked), 0);
            streak = 0;
            have_prev = 0;
        end else begin
            prev_h = h;
            prev_l = l;
            have_prev = 1;
        end
    endtask

    task automatic enable(int n);
        @(negedge clk);
        div_clk   = 1'b0;
        div_ratio = CNT_W'(n);
        en        = 1'b1;
        n_mod     = n;
        streak    = 0;
        have_prev = 0;
    endtask

    task automatic quiesce();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            div_clk = 1'b0;
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("idle_unlocked", int'(locked), 0);
        have_prev = 0;
    endtask

    task automatic good_periods(int k);
        for (int i = 0; i < k; i++) begin
            if (n_mod % 2 == 1 && i % 2 == 1) drive_period(n_mod / 2, n_mod - n_mod / 2, -1);
            else drive_period((n_mod + 1) / 2, n_mod - (n_mod + 1) / 2, -1);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_high", int'(high), 0);
        check("rst_vld", int'(period_vld), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // /3 divider, matching ratio: lock on the 4th capture, no error
        enable(3);
        good_periods(10);
        check("t1_no_err", int'(err), 0);
        check("t1_locked", int'(locked), 1);
        quiesce();

        // /3 divider checked against N=4: every capture bad
        enable(4);
        for (int i = 0; i < 6; i++) drive_period(1 + i % 2, 2 - i % 2, -1);
        quiesce();

        // Lock, timeout, relock, stretched period, relock, clear collisions
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("idle_clr_err", int'(err), 0);
        check("idle_clr_tmo", int'(timeout), 0);
        enable(3);
        good_periods(6);
        drive_period(1, 9, -1);
        good_periods(6);
        check("relock_after_tmo", int'(locked), 1);
        drive_period(2, 2, -1);
        good_periods(6);
        check("relock_after_stretch", int'(locked), 1);
        drive_period(2, 2, -1);
        drive_period(2, 1, 2);
        check("clr_loses_to_bad", int'(err), 1);
        drive_period(1, 2, 0);
        good_periods(3);
        quiesce();

        // Ratio below 2: never locks
        enable(1);
        for (int i = 0; i < 7; i++) drive_period(1, 1, -1);
        quiesce();

        // Randomised stretches; ratio input scrambled while enabled
        for (int s = 0; s < 6; s++) begin
            enable($urandom_range(3, 10));
            for (int k = 0; k < 16; k++) begin
                int kind, len, h, clr;
                if (k == 2) div_ratio = CNT_W'($urandom_range(2, 12));
                kind = $urandom_range(0, 9);
                clr  = $urandom_range(0, 5);
                clr  = (clr == 0) ? 0 : (clr == 1) ? 2 : -1;
                if (kind <= 5 || (kind == 8 && n_mod == 3)) begin
                    h   = ($urandom_range(0, 1) == 1) ? n_mod / 2 : (n_mod + 1) / 2;
                    len = n_mod;
                end else if (kind <= 7) begin
                    len = (n_mod == 3 || $urandom_range(0, 1) == 1) ? n_mod + 1 : n_mod - 1;
                    h   = $urandom_range(1, len - 1);
                end else if (kind == 8) begin
                    len = n_mod;
                    h   = (n_mod + 1) / 2 + 1;
                end else begin
                    len = 2 * n_mod + 4 + $urandom_range(0, 3);
                    h   = $urandom_range(1, 3);
                end
                drive_period(h, len - h, clr);
            end
            quiesce();
        end

        // Reset while locked, then stay disabled
        enable(3);
        drive_period(2, 2, -1);
        good_periods(6);
        check("pre_rst_locked", int'(locked), 1);
        @(negedge clk);
        div_clk = 1'b0;
        rst_n = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_period", int'(period), 0);
        check("mid_rst_high", int'(high), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_timeout", int'(timeout), 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            div_clk = (i % 3 == 0);
        end
        check("idle_after_rst", int'(locked), 0);
        check("idle_no_capture", int'(period), 0);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
